// File: rtl/universal_shift_reg.sv
// Universal shift register: shift left/right, rotate left/right, arithmetic
// shift right, parallel load and clear. A wrapping shift counter raises a
// one-cycle done pulse on every WIDTH-th shift op so the block can serialise
// or deserialise a full word without extra control logic.
module universal_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CW        = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             sil,
   input  logic             sir,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sol,
   output logic             sor,
   output logic [CW-1:0]    cnt,
   output logic             done
);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLR   = 3'b110;
   localparam logic [2:0] MODE_ASR   = 3'b111;

   // Last count value before the counter wraps and done fires.
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic             done_q;
   logic             done_d;

   // Next-state data path and shift counter for the selected operation.
   always_comb begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (en) begin
         case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], sil};
            MODE_SHR:  q_d = {sir, q_q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_LOAD: q_d = pdata;
            MODE_CLR:  q_d = {WIDTH{1'b0}};
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            default:   q_d = q_q;
         endcase
         case (mode)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: begin
               // Every shift op counts, regardless of direction.
               if (cnt_q == CNT_MAX) begin
                  cnt_d  = CNT_ZERO;
                  done_d = 1'b1;
               end else begin
                  cnt_d  = cnt_q + CNT_ONE;
                  done_d = 1'b0;
               end
            end
            MODE_LOAD, MODE_CLR: begin
               cnt_d  = CNT_ZERO;
               done_d = 1'b0;
            end
            MODE_HOLD: begin
               cnt_d  = cnt_q;
               done_d = 1'b0;
            end
            default: begin
               cnt_d  = cnt_q;
               done_d = 1'b0;
            end
         endcase
      end else begin
         q_d    = q_q;
         cnt_d  = cnt_q;
         done_d = 1'b0;
      end
   end

   // State registers; reset aborts any word in progress and drops pending done.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q    <= RESET_VAL;
         cnt_q  <= CNT_ZERO;
         done_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q    = q_q;
   assign sol  = q_q[WIDTH-1];
   assign sor  = q_q[0];
   assign cnt  = cnt_q;
   assign done = done_q;

endmodule
